// File: rtl/mat2colram_writer.sv
// Purpose : read-modify-write front end for the packed 13x(4x3-bit) colour RAM behind the matrix display.
// Latency : accepted write -> RAM read next cycle, RAM write the cycle after, ready again on the third cycle.
// Backpressure: req_ready drops for the RD/WR pair and for the whole 13-cycle clear. Discards keep ready high.
//
// Optional feature macro: COLRAM_CLEAR_EN enables the clear_start/fill_col whole-RAM fill (CLR state).
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    pixel write handshake; req_sel = matrix index 0..55, req_col = 3-bit colour
//   clear_start, fill_col  one-cycle fill request and its colour (used only with COLRAM_CLEAR_EN)
//   ram_addr, ram_rd_en    RAM word address and read strobe; ram_rdata returns one cycle after ram_rd_en
//   ram_we, ram_wdata      RAM write strobe and data
//   busy                   high whenever the FSM is not idle
//   drop                   one-cycle pulse the cycle after an unbacked/out-of-range request is accepted

module mat2colram_writer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  req_sel,
   input  logic [2:0]  req_col,
   input  logic        clear_start,
   input  logic [2:0]  fill_col,
   output logic [3:0]  ram_addr,
   output logic        ram_rd_en,
   input  logic [11:0] ram_rdata,
   output logic        ram_we,
   output logic [11:0] ram_wdata,
   output logic        busy,
   output logic        drop
);

`ifdef COLRAM_CLEAR_EN
   typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_CLR} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} state_t;
`endif

   state_t      state_q, state_d;
   logic [3:0]  addr_q, addr_d;
   logic [1:0]  lane_q, lane_d;
   logic [2:0]  col_q, col_d;
   logic        drop_q, drop_d;

`ifdef COLRAM_CLEAR_EN
   logic [3:0]  clr_cnt_q, clr_cnt_d;
   logic [2:0]  fill_q, fill_d;
`else
   // Fill inputs have no function in this build; fold them into a sink.
   logic        unused_clear_inputs;
   assign unused_clear_inputs = ^{clear_start, fill_col};
`endif

   // ---------------------------------------------------------------
   // Index decode: lane = sel / 14, slot = sel % 14.
   // Slot 9 has no RAM word, so slots 10..13 shift down to words 9..12.
   // ---------------------------------------------------------------
   logic [1:0]  dec_lane;
   logic [3:0]  dec_slot;
   logic [3:0]  dec_addr;
   logic        dec_discard;

   always_comb begin
      dec_lane = 2'd0;
      dec_slot = req_sel[3:0];
      if (req_sel >= 6'd42) begin
         dec_lane = 2'd3;
         dec_slot = 4'(req_sel - 6'd42);
      end else if (req_sel >= 6'd28) begin
         dec_lane = 2'd2;
         dec_slot = 4'(req_sel - 6'd28);
      end else if (req_sel >= 6'd14) begin
         dec_lane = 2'd1;
         dec_slot = 4'(req_sel - 6'd14);
      end
      // For sel >= 56 the truncated slot is meaningless, but the request is discarded anyway.
      dec_discard = (req_sel >= 6'd56) || (dec_slot == 4'd9);
      dec_addr    = (dec_slot > 4'd9) ? (dec_slot - 4'd1) : dec_slot;
   end

   // ---------------------------------------------------------------
   // Lane merge: replace only the latched lane of the word just read.
   // ---------------------------------------------------------------
   logic [11:0] merged;

   always_comb begin
      merged = ram_rdata;
      case (lane_q)
         2'd0:    merged[2:0]  = col_q;
         2'd1:    merged[5:3]  = col_q;
         2'd2:    merged[8:6]  = col_q;
         default: merged[11:9] = col_q;
      endcase
   end

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= 4'd0;
         lane_q    <= 2'd0;
         col_q     <= 3'd0;
         drop_q    <= 1'b0;
`ifdef COLRAM_CLEAR_EN
         clr_cnt_q <= 4'd0;
         fill_q    <= 3'd0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         lane_q    <= lane_d;
         col_q     <= col_d;
         drop_q    <= drop_d;
`ifdef COLRAM_CLEAR_EN
         clr_cnt_q <= clr_cnt_d;
         fill_q    <= fill_d;
`endif
      end
   end

   // ---------------------------------------------------------------
   // Next state and outputs. RAM outputs are decoded from state so an
   // asynchronous reset silences them immediately.
   // ---------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      lane_d    = lane_q;
      col_d     = col_q;
      drop_d    = 1'b0;
`ifdef COLRAM_CLEAR_EN
      clr_cnt_d = clr_cnt_q;
      fill_d    = fill_q;
`endif
      req_ready = 1'b0;
      ram_rd_en = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = 4'd0;
      ram_wdata = 12'd0;

      case (state_q)
         ST_IDLE: begin
`ifdef COLRAM_CLEAR_EN
            // A fill wins over a simultaneous write; the write is held off by ready.
            req_ready = !clear_start;
            if (clear_start) begin
               state_d   = ST_CLR;
               clr_cnt_d = 4'd0;
               fill_d    = fill_col;
            end
`else
            req_ready = 1'b1;
`endif
            if (req_valid && req_ready) begin
               if (dec_discard) begin
                  drop_d = 1'b1;
               end else begin
                  addr_d  = dec_addr;
                  lane_d  = dec_lane;
                  col_d   = req_col;
                  state_d = ST_RD;
               end
            end
         end

         ST_RD: begin
            ram_rd_en = 1'b1;
            ram_addr  = addr_q;
            state_d   = ST_WR;
         end

         ST_WR: begin
            ram_we    = 1'b1;
            ram_addr  = addr_q;
            ram_wdata = merged;
            state_d   = ST_IDLE;
         end

`ifdef COLRAM_CLEAR_EN
         ST_CLR: begin
            ram_we    = 1'b1;
            ram_addr  = clr_cnt_q;
            ram_wdata = {4{fill_q}};
            if (clr_cnt_q == 4'd12) begin
               clr_cnt_d = 4'd0;
               state_d   = ST_IDLE;
            end else begin
               clr_cnt_d = clr_cnt_q + 4'd1;
            end
         end
`endif

         default: state_d = ST_IDLE;
      endcase
   end

   assign busy = (state_q != ST_IDLE);
   assign drop = drop_q;

endmodule

// File: doc/mat2colram_writer.md
# mat2colram_writer

- Write side of the packed colour RAM that the matrix display reads.
- Accepts single-pixel colour writes addressed by matrix select index (0..55) and performs a read-modify-write of the 3-bit lane inside the matching 12-bit colour word.
- The colour RAM is external: 13 words, addresses 0..12, synchronous read with 1-cycle latency.
- Sits between the ant-simulation update logic and the colour RAM, so the display path can stay purely combinational.

## Interface
- No parameters. Geometry is fixed: 13 words × 4 lanes × 3 bits.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  write request present.
- req_ready  out  1  request accepted on a cycle where req_valid && req_ready.
- req_sel  in  6  matrix select index.
- req_col  in  3  colour to store.
- clear_start  in  1  one-cycle pulse that requests a fill of the whole RAM (see Configuration).
- fill_col  in  3  fill colour for clear.
- ram_addr  out  4  RAM word address.
- ram_rd_en  out  1  RAM read strobe.
- ram_rdata  in  12  RAM read data, valid the cycle after ram_rd_en.
- ram_we  out  1  RAM write strobe.
- ram_wdata  out  12  RAM write data.
- busy  out  1  high whenever the block is not IDLE.
- drop  out  1  one-cycle pulse when an accepted request is discarded.

## Operation
- Index decode:
  - lane = req_sel / 14; slot = req_sel % 14.
  - Word address: slot 0..8 → 0..8; slot 10..13 → 9..12; slot 9 is unbacked.
  - Lane n occupies word bits [3n+2:3n].
- Discard rule: a request with req_sel ≥ 56 or slot = 9 is accepted and discarded. drop pulses in the cycle after acceptance; no RAM access occurs.
- FSM states: IDLE, RD, WR, CLR.
  - IDLE:
    - req_ready = !clear_start.
    - On clear_start → CLR. clear_start has priority over req_valid in the same cycle; that request is not accepted.
    - On an accepted valid request: latch address, lane and colour, then → RD.
    - On an accepted discarded request: stay in IDLE with drop = 1 next cycle.
  - RD: ram_rd_en = 1, ram_addr = latched address. → WR.
  - WR: ram_we = 1, ram_addr = latched address, ram_wdata = ram_rdata with only the latched lane replaced by the latched colour; the other 9 bits pass through unchanged. → IDLE.
  - CLR: ram_we = 1, ram_wdata = {4{fill_col latched at start}}, ram_addr = clear counter 0..12, incrementing each cycle. After address 12 → IDLE.
- clear_start outside IDLE is ignored.
- Reset values: state = IDLE, req_ready = 1, ram_rd_en = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, busy = 0, drop = 0, clear counter = 0.
- Reset mid-operation aborts immediately; no partial write is issued after rst_n deasserts.

## Timing
- Accept at edge T. RD during cycle T+1, WR during cycle T+2, IDLE with req_ready = 1 at T+3.
- Throughput: 1 write per 3 cycles with back-to-back requests.
- Discarded request: req_ready stays high, so the next request is accepted in the cycle after.
- Clear: 13 write cycles; busy high for exactly 13 cycles; req_ready low throughout.
- ram_rd_en and ram_we are never high in the same cycle.

## Configuration
- COLRAM_CLEAR_EN defined: clear_start and fill_col operate as described above.
- COLRAM_CLEAR_EN undefined:
  - CLR state and clear counter are not built.
  - clear_start and fill_col are ignored.
  - req_ready in IDLE is constantly 1.

## Test plan
- RAM word 4 = 12'hFFF; req_sel = 18, req_col = 3'b010 → ram_rd_en with addr 4 at T+1; ram_we with addr 4, wdata 12'hFD7 at T+2; req_ready high at T+3.
- Word 12 = 12'h000; req_sel = 55, req_col = 3'b111 → write addr 12, wdata 12'hE00.
- req_sel = 9, then 37, then 60 → each accepted, drop pulses once per request, no ram_rd_en or ram_we.
- Same-cycle clear_start and req_valid with fill_col = 3'b101 (COLRAM_CLEAR_EN defined) → request not accepted; addrs 0..12 written with 12'hB6D on 13 consecutive cycles; request then accepted.
- Assert rst_n low during RD → no ram_we; all outputs at reset values; next request is processed normally.
- Build without COLRAM_CLEAR_EN; pulse clear_start → busy stays 0, no RAM activity.
